// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package    : aes_ctrl_pkg                                                    |
// | Description: State encoding and AES round-count constants for round control |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
package aes_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [7:0] NR_128 = 8'd10;
  localparam logic [7:0] NR_192 = 8'd12;
  localparam logic [7:0] NR_256 = 8'd14;

endpackage : aes_ctrl_pkg
`default_nettype wire

// File: rtl/down_count_core.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module     : down_count_core                                                 |
// | Description: WIDTH-bit down-counter built as a borrow chain of JK cells,    |
// |              with synchronous clear, parallel load and zero detect          |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module down_count_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] borrow;

  assign borrow[0] = en_i;

  // Clear beats load beats count; J/K encode set, reset or toggle per stage.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic j;
    logic k;

    if (i > 0) begin : g_borrow
      assign borrow[i] = borrow[i-1] & ~count[i-1];
    end

    assign j = clear_i ? 1'b0 : (load_i ?  load_value_i[i] : borrow[i]);
    assign k = clear_i ? 1'b1 : (load_i ? ~load_value_i[i] : borrow[i]);

    jk_flip_flop u_jk (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j),
      .k     (k),
      .q     (count[i])
    );
  end

  assign count_o = count;
  assign zero_o  = ~|count;

endmodule : down_count_core
`default_nettype wire

// File: rtl/jk_flip_flop.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module     : jk_flip_flop                                                    |
// | Description: JK flip-flop cell with asynchronous active-low reset           |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module jk_flip_flop (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule : jk_flip_flop
`default_nettype wire

// File: rtl/round_down_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module     : round_down_counter                                              |
// | Description: Loadable AES round down-counter with valid/ready load, count   |
// |              enable, abort and one-cycle terminal-count pulse.              |
// |              Define ROUND_DOWN_COUNTER_AUTORELOAD_EN for periodic reload.   |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module round_down_counter
  import aes_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             EN,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             tc_q;
  logic             tc_d;
  logic             busy_q;
  logic             done_q;

  logic             core_clear;
  logic             core_load;
  logic             core_en;
  logic [WIDTH-1:0] core_value;
  logic [WIDTH-1:0] count;
  logic             count_zero;
  logic             count_one;
  logic             load_fire;

  assign load_ready = (state_q == IDLE) || (state_q == DONE);
  assign load_fire  = load_valid & load_ready;
  assign count_one  = (count == WIDTH'(1));

`ifdef ROUND_DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '0;
    end else if (load_fire) begin
      reload_q <= load_value;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    tc_d       = 1'b0;
    core_clear = 1'b0;
    core_load  = 1'b0;
    core_en    = 1'b0;
    core_value = load_value;

    if (abort) begin
      state_d    = IDLE;
      core_clear = 1'b1;
    end else if (load_fire) begin
      core_load = 1'b1;
      if (load_value == '0) begin
        state_d = DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (EN && !count_zero) begin
            if (count_one) begin
              tc_d = 1'b1;
`ifdef ROUND_DOWN_COUNTER_AUTORELOAD_EN
              core_load  = 1'b1;
              core_value = reload_q;
`else
              core_en = 1'b1;
              state_d = DONE;
`endif
            end else begin
              core_en = 1'b1;
            end
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d    = IDLE;
          core_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (core_clear),
    .load_i       (core_load),
    .load_value_i (core_value),
    .en_i         (core_en),
    .count_o      (count),
    .zero_o       (count_zero)
  );

  assign Q    = count;
  assign busy = busy_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule : round_down_counter
`default_nettype wire

// File: tb/tb_round_down_counter.sv
`default_nettype none
// Directed self-checking bench for round_down_counter (8-bit configuration).
module tb_round_down_counter;
  import aes_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_value = 8'd0;
  logic       EN = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] Q;
  logic       busy;
  logic       tc;
  logic       done;

  int passed = 0;
  int total  = 0;

  round_down_counter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .EN         (EN),
    .abort      (abort),
    .Q          (Q),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    total++; if (Q !== 8'd0)      $display("FAIL reset_q: got %0d want 0", Q); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", load_ready); else passed++;
    total++; if (busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (tc !== 1'b0)     $display("FAIL reset_tc: got %b want 0", tc); else passed++;
    total++; if (done !== 1'b0)   $display("FAIL reset_done: got %b want 0", done); else passed++;
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++; if (Q !== 8'd0)      $display("FAIL reset_release_q: got %0d want 0", Q); else passed++;
  endtask

  task automatic test_load_count();
    load_valid = 1'b1; load_value = NR_128; EN = 1'b1;
    tick();
    load_valid = 1'b0;
    total++; if (Q !== 8'd10)  $display("FAIL t1_load_q: got %0d want 10", Q); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL t1_busy: got %b want 1", busy); else passed++;
    total++; if (load_ready !== 1'b0) $display("FAIL t1_ready_run: got %b want 0", load_ready); else passed++;
    for (int i = 9; i >= 1; i--) begin
      tick();
      total++; if (Q !== 8'(i)) $display("FAIL t1_step_q: got %0d want %0d", Q, i); else passed++;
      total++; if (tc !== 1'b0)  $display("FAIL t1_step_tc at %0d: got %b want 0", i, tc); else passed++;
    end
    tick();
    total++; if (Q !== 8'd0)    $display("FAIL t1_final_q: got %0d want 0", Q); else passed++;
    total++; if (tc !== 1'b1)   $display("FAIL t1_tc: got %b want 1", tc); else passed++;
    total++; if (done !== 1'b1) $display("FAIL t1_done: got %b want 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL t1_busy_end: got %b want 0", busy); else passed++;
    tick();
    total++; if (tc !== 1'b0)   $display("FAIL t1_tc_one_cycle: got %b want 0", tc); else passed++;
    total++; if (done !== 1'b1) $display("FAIL t1_done_hold: got %b want 1", done); else passed++;
    total++; if (Q !== 8'd0)    $display("FAIL t1_no_wrap: got %0d want 0", Q); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL t1_ready_done: got %b want 1", load_ready); else passed++;
  endtask

  task automatic test_en_toggle();
    logic [7:0] exp;
    logic       en_now;
    load_valid = 1'b1; load_value = NR_256; EN = 1'b0;
    tick();
    load_valid = 1'b0;
    total++; if (Q !== 8'd14) $display("FAIL t2_load_q: got %0d want 14", Q); else passed++;
    exp = 8'd14;
    for (int c = 0; c < 28; c++) begin
      en_now = (c % 2 == 0);
      EN = en_now;
      tick();
      if (en_now && exp != 8'd0) exp = exp - 8'd1;
      total++; if (Q !== exp) $display("FAIL t2_q cycle %0d: got %0d want %0d", c, Q, exp); else passed++;
      total++; if (tc !== (c == 26)) $display("FAIL t2_tc cycle %0d: got %b want %b", c, tc, (c == 26)); else passed++;
    end
    total++; if (done !== 1'b1) $display("FAIL t2_done: got %b want 1", done); else passed++;
    EN = 1'b1;
  endtask

  task automatic test_load_zero();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (done !== 1'b0) $display("FAIL t3_idle_done: got %b want 0", done); else passed++;
    load_valid = 1'b1; load_value = 8'd0;
    tick();
    load_valid = 1'b0;
    total++; if (tc !== 1'b1)   $display("FAIL t3_tc: got %b want 1", tc); else passed++;
    total++; if (done !== 1'b1) $display("FAIL t3_done: got %b want 1", done); else passed++;
    total++; if (Q !== 8'd0)    $display("FAIL t3_q: got %0d want 0", Q); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL t3_busy: got %b want 0", busy); else passed++;
    tick();
    total++; if (tc !== 1'b0)   $display("FAIL t3_tc_pulse: got %b want 0", tc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL t3_busy_after: got %b want 0", busy); else passed++;
  endtask

  task automatic test_abort();
    load_valid = 1'b1; load_value = NR_192; EN = 1'b1;
    tick();
    load_valid = 1'b0;
    total++; if (Q !== 8'd12) $display("FAIL t4_load_q: got %0d want 12", Q); else passed++;
    repeat (7) tick();
    total++; if (Q !== 8'd5)  $display("FAIL t4_q5: got %0d want 5", Q); else passed++;
    abort = 1'b1; load_valid = 1'b1; load_value = 8'd3;
    tick();
    abort = 1'b0; load_valid = 1'b0;
    total++; if (Q !== 8'd0)    $display("FAIL t4_q: got %0d want 0", Q); else passed++;
    total++; if (tc !== 1'b0)   $display("FAIL t4_tc: got %b want 0", tc); else passed++;
    total++; if (done !== 1'b0) $display("FAIL t4_done: got %b want 0", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL t4_busy: got %b want 0", busy); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL t4_ready: got %b want 1", load_ready); else passed++;
    tick();
    total++; if (Q !== 8'd0)    $display("FAIL t4_idle_hold: got %0d want 0", Q); else passed++;
    total++; if (tc !== 1'b0)   $display("FAIL t4_no_tc: got %b want 0", tc); else passed++;
  endtask

  task automatic test_run_ignores_load();
    load_valid = 1'b1; load_value = NR_128; EN = 1'b1;
    tick();
    load_value = 8'd7;
    tick();
    load_valid = 1'b0;
    total++; if (Q !== 8'd9) $display("FAIL t5_ignored: got %0d want 9", Q); else passed++;
    repeat (8) tick();
    total++; if (Q !== 8'd1) $display("FAIL t5_q1: got %0d want 1", Q); else passed++;
    tick();
    total++; if (Q !== 8'd0)    $display("FAIL t5_q0: got %0d want 0", Q); else passed++;
    total++; if (tc !== 1'b1)   $display("FAIL t5_tc: got %b want 1", tc); else passed++;
    load_valid = 1'b1; load_value = 8'd7;
    tick();
    load_valid = 1'b0;
    total++; if (Q !== 8'd7)    $display("FAIL t5_reload_q: got %0d want 7", Q); else passed++;
    total++; if (done !== 1'b0) $display("FAIL t5_done_clr: got %b want 0", done); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL t5_busy: got %b want 1", busy); else passed++;
  endtask

  task automatic test_async_reset();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    load_valid = 1'b1; load_value = NR_128; EN = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    total++; if (Q !== 8'd6) $display("FAIL t6_q6: got %0d want 6", Q); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (Q !== 8'd0)    $display("FAIL t6_async_q: got %0d want 0", Q); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL t6_async_busy: got %b want 0", busy); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL t6_async_ready: got %b want 1", load_ready); else passed++;
    total++; if (tc !== 1'b0 || done !== 1'b0) $display("FAIL t6_async_tc_done: got %b%b want 00", tc, done); else passed++;
    #2 rst = 1'b1;
    tick();
    total++; if (Q !== 8'd0)    $display("FAIL t6_after_q: got %0d want 0", Q); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL t6_after_busy: got %b want 0", busy); else passed++;
  endtask

`ifdef ROUND_DOWN_COUNTER_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [7:0] exp_seq [9] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
    load_valid = 1'b1; load_value = 8'd3; EN = 1'b1;
    tick();
    load_valid = 1'b0;
    total++; if (Q !== 8'd3) $display("FAIL ar_load_q: got %0d want 3", Q); else passed++;
    for (int c = 0; c < 9; c++) begin
      tick();
      total++; if (Q !== exp_seq[c]) $display("FAIL ar_q step %0d: got %0d want %0d", c, Q, exp_seq[c]); else passed++;
      total++; if (tc !== (c % 3 == 2)) $display("FAIL ar_tc step %0d: got %b want %b", c, tc, (c % 3 == 2)); else passed++;
      total++; if (done !== 1'b0) $display("FAIL ar_done step %0d: got %b want 0", c, done); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL ar_busy step %0d: got %b want 1", c, busy); else passed++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (Q !== 8'd0 || busy !== 1'b0) $display("FAIL ar_abort: got q=%0d busy=%b want q=0 busy=0", Q, busy); else passed++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef ROUND_DOWN_COUNTER_AUTORELOAD_EN
    test_load_zero();
    test_abort();
    test_autoreload();
    test_async_reset();
`else
    test_load_count();
    test_en_toggle();
    test_load_zero();
    test_abort();
    test_run_ignores_load();
    test_async_reset();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_round_down_counter
`default_nettype wire
